// File: rtl/decode_stage.sv
// Single-entry decode stage: holds one fetched instruction, decodes it combinationally, and
// interlocks on load-use. Define WB_FORWARD_EN to bypass the writeback bus onto operand reads.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc_plus_4,
    input  logic              flush,
    output logic [RA_W-1:0]   rf_raddr1,
    output logic [RA_W-1:0]   rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_en,
    input  logic [RA_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc_plus_4,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [RA_W-1:0]   out_rs,
    output logic [RA_W-1:0]   out_rt,
    output logic [RA_W-1:0]   out_dst,
    output logic [5:0]        out_alu_op,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_mem_write,
    output logic              out_alu_src,
    output logic [1:0]        out_branch,
    output logic              out_illegal
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_ANDI = 6'h0C,
                           OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B,
                           OP_BEQ = 6'h04, OP_BNE = 6'h05;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext16(input logic [15:0] v);
        return {{(DATA_W-16){1'b0}}, v};
    endfunction

    function automatic logic [DATA_W-1:0] zext32(input logic [31:0] v);
        logic [DATA_W-1:0] r;
        r       = '0;
        r[31:0] = v;
        return r;
    endfunction

    logic              hold_valid_q, hold_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic              lu_pend_q, lu_pend_d;
    logic [RA_W-1:0]   lu_dst_q, lu_dst_d;

    logic [5:0]      opcode;
    logic [RA_W-1:0] rs, rt, rd;
    logic [15:0]     imm16;
    logic            rs_used, rt_used, dec_reg_write;
    logic            hazard, fire, capture;

    assign opcode = instr_q[31:26];
    assign rs     = RA_W'(instr_q[25:21]);
    assign rt     = RA_W'(instr_q[20:16]);
    assign rd     = RA_W'(instr_q[15:11]);
    assign imm16  = instr_q[15:0];

    always_comb begin
        dec_reg_write  = 1'b0;
        out_mem_to_reg = 1'b0;
        out_mem_write  = 1'b0;
        out_alu_src    = 1'b0;
        out_branch     = 2'b00;
        out_illegal    = 1'b0;
        out_imm        = '0;
        out_dst        = rt;
        out_alu_op     = opcode;
        rs_used        = 1'b1;
        rt_used        = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                dec_reg_write = 1'b1;
                rt_used       = 1'b1;
                out_dst       = rd;
                out_alu_op    = instr_q[5:0];
                out_imm       = sext16(imm16);
            end
            OP_ADDI, OP_ADDIU: begin
                dec_reg_write = 1'b1;
                out_alu_src   = 1'b1;
                out_imm       = sext16(imm16);
            end
            OP_ANDI, OP_ORI: begin
                dec_reg_write = 1'b1;
                out_alu_src   = 1'b1;
                out_imm       = zext16(imm16);
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                out_alu_src   = 1'b1;
                rs_used       = 1'b0;
                out_imm       = zext32({imm16, 16'h0000});
            end
            OP_LW: begin
                dec_reg_write  = 1'b1;
                out_mem_to_reg = 1'b1;
                out_alu_src    = 1'b1;
                out_imm        = sext16(imm16);
            end
            OP_SW: begin
                out_mem_write = 1'b1;
                out_alu_src   = 1'b1;
                rt_used       = 1'b1;
                out_imm       = sext16(imm16);
            end
            OP_BEQ, OP_BNE: begin
                out_branch = (opcode == OP_BEQ) ? 2'b01 : 2'b10;
                rt_used    = 1'b1;
                out_imm    = sext16(imm16);
            end
            default: out_illegal = 1'b1;
        endcase
    end

    // Writes to $0 and the all-zero NOP never reach the register file
    assign out_reg_write = dec_reg_write && (out_dst != '0) && (instr_q != 32'h0);
    assign out_rs        = rs;
    assign out_rt        = rt;
    assign rf_raddr1     = rs;
    assign rf_raddr2     = rt;
    assign out_pc_plus_4 = pc4_q;

`ifdef WB_FORWARD_EN
    assign out_rd1 = (wb_en && (wb_addr == rs) && (rs != '0)) ? wb_data : rf_rdata1;
    assign out_rd2 = (wb_en && (wb_addr == rt) && (rt != '0)) ? wb_data : rf_rdata2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_en, wb_addr, wb_data};
    assign out_rd1   = rf_rdata1;
    assign out_rd2   = rf_rdata2;
`endif

    assign hazard    = hold_valid_q && lu_pend_q &&
                       (((lu_dst_q == rs) && rs_used) || ((lu_dst_q == rt) && rt_used));
    assign out_valid = hold_valid_q && !hazard;
    assign in_ready  = !flush && (!hold_valid_q || (out_ready && !hazard));
    assign fire      = out_valid && out_ready;
    assign capture   = in_valid && in_ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        lu_pend_d    = lu_pend_q;
        lu_dst_d     = lu_dst_q;
        if (capture) begin
            instr_d = in_instr;
            pc4_d   = in_pc_plus_4;
        end
        if (flush)        hold_valid_d = 1'b0;
        else if (capture) hold_valid_d = 1'b1;
        else if (fire)    hold_valid_d = 1'b0;
        // A bubble cycle seen by a ready consumer retires the pending load window
        if (fire) begin
            lu_pend_d = (opcode == OP_LW) && (out_dst != '0);
            lu_dst_d  = (opcode == OP_LW) ? out_dst : '0;
        end else if (out_ready) begin
            lu_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= 1'b0;
            instr_q      <= '0;
            pc4_q        <= '0;
            lu_pend_q    <= 1'b0;
            lu_dst_q     <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            lu_pend_q    <= lu_pend_d;
            lu_dst_q     <= lu_dst_d;
        end
    end
endmodule
